display_sequencer: RTL and testbench
====================================

// Module: display_sequencer
// PURPOSE
// - Parametrised successor of the game's per-state text display driver. Maps the game FSM state
//   and the bulls/cows counts onto NUM_DIGITS 6-bit digit codes {blank, value[3:0], dp}.
// - Adds registered outputs, a timed result-hold with a done pulse, and a digit-scan multiplexer.
// - Sits between the game controller and the 7-segment driver.
// PARAMETERS
// - NUM_DIGITS    8     number of digit positions; must be >= 8; positions 9+ always blank
// - COUNT_W       4     width of bulls/cows inputs
// - HOLD_CYCLES   100   clocks a result screen is held before result_done pulses; must be >= 1
// - SCAN_DIV      1000  clocks per scan position; must be >= 1
// - BLINK_CYCLES  50    clocks per WIN blink half-period (used only with DISP_BLINK_EN)
// PORTS
// - clock        in   1              system clock, rising edge
// - reset        in   1              asynchronous, active-high
// - state_i      in   3              game state: 0 SECRET_J1, 1 SECRET_J2, 2 GUESS_J1, 3 GUESS_J2,
//                                    4 RESULT_J1, 5 RESULT_J2, 6 WIN, 7 FIM
// - bulls_i      in   COUNT_W        bulls count
// - cows_i       in   COUNT_W        cows count
// - digits_o     out  6*NUM_DIGITS   digit k at bits [6k+5:6k]; d1 is k=0
// - scan_sel_o   out  $clog2(NUM_DIGITS)  currently scanned position
// - scan_code_o  out  6              digits_o code at scan_sel_o
// - result_done_o out  1             1-cycle pulse when the result hold expires
// BEHAVIOUR
// - One clock domain (clock). Reset is asynchronous, active-high. All outputs are registered.
// - Reset values:
//   - every digit = 6'b100000 (blank)
//   - scan_sel_o = 0, scan_code_o = 6'b100000, result_done_o = 0
//   - FSM = SHOW, counters = 0
// - Latency: digits_o reflects state_i one clock after the sampling edge.
// - Text codes d1..d8, 6-bit:
//   - SECRET_Jn: J,n,_,S,E,T,U,P
//   - GUESS_Jn:  J,n,_,G,U,E,S,S
//   - RESULT_Jn: {0,B,0},_,T,O,{0,C,0},_,V,A
//   - WIN:       B,U,L,L,S,E,Y,E
//   - FIM:       all blank
//   - Letter codes: J=0B, S=05, E=0E, T=07, U/V=0C, P=0D, G=06, O=00, B=08, L=09, Y=04, A=0A.
//     Digit n is 01 or 02. Blank is 20 hex.
// - B and C are bulls_i and cows_i captured on entry to a RESULT state and frozen for its duration.
//   Values > 15 saturate to 4'hF (relevant when COUNT_W > 4).
// - State-change detect: prev_state is registered. change = (state_i != prev_state).
//   prev_state resets to 7 (FIM).
// - FSM:
//   - SHOW: static text.
//     - On entry to RESULT_J1/J2: latch counts, clear hold_cnt, go HOLD.
//   - HOLD: hold_cnt increments each clock.
//     - At hold_cnt == HOLD_CYCLES-1: pulse result_done_o for 1 clock, go HELD.
//   - HELD: result text stays displayed. No further pulses.
//   - Any change while in HOLD or HELD: go SHOW (or re-enter HOLD if the new state is the other
//     RESULT). hold_cnt clears. No done pulse for an aborted hold.
//   - Direct RESULT_J1 -> RESULT_J2: treated as a fresh entry; counts are relatched.
// - Scan:
//   - scan_div counts 0..SCAN_DIV-1; on wrap, scan_sel_o advances.
//   - scan_sel_o wraps NUM_DIGITS-1 -> 0.
//   - scan_code_o is registered from the updated digit array, one clock behind digits_o.
// - Reset mid-hold: immediate return to reset values. No pulse.
// CONFIGURATION
// - DISP_BLINK_EN defined:
//   - In WIN, digits_o alternates between WIN text and all-blank every BLINK_CYCLES clocks.
//   - Starts visible on entry. Blink counter clears on any state change.
// - DISP_BLINK_EN undefined: WIN text is static. Blink logic and BLINK_CYCLES are unused.
// TESTING
// 1. Reset asserted mid-run -> all digits 6'h20, scan_sel 0, result_done 0 on the same cycle
//    (asynchronous).
// 2. state_i=0 -> one clock later d1..d8 = 0B,01,20,05,0E,07,0C,0D. state_i=3 -> 0B,02,20,06,0C,0E,05,05.
// 3. HOLD_CYCLES=4, state_i=4, bulls=2, cows=1 -> d1=6'h04, d5=6'h02. result_done pulses exactly
//    once, 4 clocks after entry. Changing bulls mid-hold leaves d1 unchanged.
// 4. Enter RESULT_J1, return to GUESS_J1 after 2 clocks (HOLD_CYCLES=4) -> no pulse.
//    COUNT_W=5, bulls=20 -> d1 = 6'h1E.
// 5. SCAN_DIV=2, NUM_DIGITS=10 -> scan_sel steps every 2 clocks and wraps 9->0.
//    Positions 8 and 9 read 6'h20.
// 6. DISP_BLINK_EN, BLINK_CYCLES=3, state_i=6 -> text for 3 clocks, blank for 3 clocks, repeating.
//    Without the macro -> text is constant.

Source files
------------

// File: rtl/display_sequencer.sv
// display_sequencer: maps game state and bulls/cows onto registered digit codes with result hold and scan mux.
// Define DISP_BLINK_EN to blink the WIN screen every BLINK_CYCLES clocks.
module display_sequencer #(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_W      = 4,
    parameter int HOLD_CYCLES  = 100,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_CYCLES = 50
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [2:0]                    state_i,
    input  logic [COUNT_W-1:0]            bulls_i,
    input  logic [COUNT_W-1:0]            cows_i,
    output logic [6*NUM_DIGITS-1:0]       digits_o,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_sel_o,
    output logic [5:0]                    scan_code_o,
    output logic                          result_done_o
);
    localparam int SEL_W  = $clog2(NUM_DIGITS);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int DIV_W  = $clog2(SCAN_DIV + 1);
    localparam logic [5:0]        BLANK     = 6'h20;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 8 || HOLD_CYCLES < 1 || SCAN_DIV < 1 || BLINK_CYCLES < 1) begin : g_bad_params
        $error("display_sequencer: illegal parameter value");
    end

    typedef enum logic [1:0] {SHOW, HOLD, HELD} fsm_t;

    fsm_t                    fsm;
    logic [2:0]              prev_state;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [DIV_W-1:0]        div_q;
    logic [3:0]              bulls_q, cows_q, bulls_n, cows_n;
    logic                    change, is_res, blank_text;
    logic [SEL_W-1:0]        sel_n;
    logic [6*NUM_DIGITS-1:0] digits_n;
`ifdef DISP_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase, blink_phase_n, blink_wrap;
`endif

    function automatic logic [3:0] sat(input logic [COUNT_W-1:0] v);
        return (32'(v) > 32'd15) ? 4'hF : 4'(v);
    endfunction

    // d1 sits in the low six bits, so each text reads right-to-left here
    function automatic logic [47:0] text_of(input logic [2:0] s, input logic [3:0] b, input logic [3:0] c);
        logic [5:0] n;
        n = {4'd0, s[0], ~s[0]};
        case (s)
            3'd0, 3'd1: text_of = {6'h0D, 6'h0C, 6'h07, 6'h0E, 6'h05, BLANK, n, 6'h0B};
            3'd2, 3'd3: text_of = {6'h05, 6'h05, 6'h0E, 6'h0C, 6'h06, BLANK, n, 6'h0B};
            3'd4, 3'd5: text_of = {6'h0A, 6'h0C, BLANK, 1'b0, c, 1'b0, 6'h00, 6'h07, BLANK, 1'b0, b, 1'b0};
            3'd6:       text_of = {6'h0E, 6'h04, 6'h0E, 6'h05, 6'h09, 6'h09, 6'h0C, 6'h08};
            default:    text_of = {8{BLANK}};
        endcase
    endfunction

    always_comb begin
        change  = state_i != prev_state;
        is_res  = state_i[2:1] == 2'b10;
        bulls_n = (change && is_res) ? sat(bulls_i) : bulls_q;
        cows_n  = (change && is_res) ? sat(cows_i) : cows_q;
        sel_n   = (div_q != DIV_LAST) ? scan_sel_o : (scan_sel_o == SEL_LAST) ? '0 : scan_sel_o + 1'b1;
`ifdef DISP_BLINK_EN
        blink_wrap    = blink_cnt == BLINK_LAST;
        blink_phase_n = !change && (blink_phase ^ blink_wrap);
        blank_text    = state_i == 3'd6 && blink_phase_n;
`else
        blank_text = 1'b0;
`endif
        digits_n        = {NUM_DIGITS{BLANK}};
        digits_n[47:0]  = blank_text ? {8{BLANK}} : text_of(state_i, bulls_n, cows_n);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm           <= SHOW;
            prev_state    <= 3'd7;
            hold_cnt      <= '0;
            div_q         <= '0;
            bulls_q       <= '0;
            cows_q        <= '0;
            digits_o      <= {NUM_DIGITS{BLANK}};
            scan_sel_o    <= '0;
            scan_code_o   <= BLANK;
            result_done_o <= 1'b0;
`ifdef DISP_BLINK_EN
            blink_cnt     <= '0;
            blink_phase   <= 1'b0;
`endif
        end else begin
            prev_state    <= state_i;
            bulls_q       <= bulls_n;
            cows_q        <= cows_n;
            digits_o      <= digits_n;
            div_q         <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            scan_sel_o    <= sel_n;
            scan_code_o   <= digits_o[6*sel_n +: 6];
            result_done_o <= 1'b0;
`ifdef DISP_BLINK_EN
            blink_cnt     <= (change || blink_wrap) ? '0 : blink_cnt + 1'b1;
            blink_phase   <= blink_phase_n;
`endif
            // any state change aborts a running hold without a done pulse
            if (change) begin
                fsm      <= is_res ? HOLD : SHOW;
                hold_cnt <= '0;
            end else if (fsm == HOLD) begin
                if (hold_cnt == HOLD_LAST) begin
                    fsm           <= HELD;
                    result_done_o <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: random and directed stimulus checked against a behavioural display model.
module tb_display_sequencer;
    localparam int ND = 10, CW = 5, HC = 4, SD = 2, BL = 3, SW = $clog2(ND);
    localparam logic [5:0] T_SECRET [8] = '{6'h0B, 6'h01, 6'h20, 6'h05, 6'h0E, 6'h07, 6'h0C, 6'h0D};
    localparam logic [5:0] T_GUESS  [8] = '{6'h0B, 6'h01, 6'h20, 6'h06, 6'h0C, 6'h0E, 6'h05, 6'h05};
    localparam logic [5:0] T_RESULT [8] = '{6'h00, 6'h20, 6'h07, 6'h00, 6'h00, 6'h20, 6'h0C, 6'h0A};
    localparam logic [5:0] T_WIN    [8] = '{6'h08, 6'h0C, 6'h09, 6'h09, 6'h05, 6'h0E, 6'h04, 6'h0E};

    logic          clock = 0, reset = 1;
    logic [2:0]    state_i = 3'd7;
    logic [CW-1:0] bulls_i = '0, cows_i = '0;
    logic [6*ND-1:0] digits_o;
    logic [SW-1:0] scan_sel_o;
    logic [5:0]    scan_code_o;
    logic          result_done_o;

    display_sequencer #(.NUM_DIGITS(ND), .COUNT_W(CW), .HOLD_CYCLES(HC), .SCAN_DIV(SD), .BLINK_CYCLES(BL)) dut (
        .clock(clock), .reset(reset), .state_i(state_i), .bulls_i(bulls_i), .cows_i(cows_i),
        .digits_o(digits_o), .scan_sel_o(scan_sel_o), .scan_code_o(scan_code_o), .result_done_o(result_done_o));

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] mcode(int s, int pos, int lb, int lc, int age);
        if (pos >= 8 || s == 7) return 6'h20;
`ifdef DISP_BLINK_EN
        if (s == 6 && (age / BL) % 2 == 1) return 6'h20;
`endif
        if (s <= 1) return pos == 1 ? 6'(s + 1) : T_SECRET[pos];
        if (s <= 3) return pos == 1 ? 6'(s - 1) : T_GUESS[pos];
        if (s <= 5) return pos == 0 ? 6'(lb * 2) : pos == 4 ? 6'(lc * 2) : T_RESULT[pos];
        return T_WIN[pos];
    endfunction

    function automatic int sat(int v);
        return v > 15 ? 15 : v;
    endfunction

    // model: age = clocks since the last state change, k = clocks since reset release
    int m_prev, m_age, m_lb, m_lc, m_k, m_s;
    bit m_chg;
    logic [5:0] m_dig [ND];
    logic [6*ND-1:0] exp_dig;
    logic [SW-1:0] exp_sel;
    logic [5:0] exp_code;
    logic exp_done;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_prev = 7; m_age = 0; m_lb = 0; m_lc = 0; m_k = 0;
            foreach (m_dig[i]) m_dig[i] = 6'h20;
            exp_sel = '0; exp_code = 6'h20; exp_done = 1'b0;
        end else begin
            m_s = int'(state_i);
            m_chg = m_s != m_prev;
            m_prev = m_s;
            if (m_chg) begin
                m_age = 0;
                if (m_s == 4 || m_s == 5) begin
                    m_lb = sat(int'(bulls_i));
                    m_lc = sat(int'(cows_i));
                end
            end else m_age++;
            exp_done = !m_chg && (m_s == 4 || m_s == 5) && m_age == HC;
            m_k++;
            exp_sel = SW'((m_k / SD) % ND);
            exp_code = m_dig[exp_sel];
            foreach (m_dig[i]) m_dig[i] = mcode(m_s, i, m_lb, m_lc, m_age);
        end
        foreach (m_dig[i]) exp_dig[6*i +: 6] = m_dig[i];
        #1;
        chk("model_digits", 64'(digits_o), 64'(exp_dig));
        chk("model_scan_sel", 64'(scan_sel_o), 64'(exp_sel));
        chk("model_scan_code", 64'(scan_code_o), 64'(exp_code));
        chk("model_done", 64'(result_done_o), 64'(exp_done));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int pulses, idx, len;
    bit found, vis;
    logic [5:0] d1_first;

    initial begin
        repeat (2) @(posedge clock);
        #2;
        chk("reset_digits", 64'(digits_o), 64'({ND{6'h20}}));
        chk("reset_sel", 64'(scan_sel_o), 64'd0);
        chk("reset_code", 64'(scan_code_o), 64'h20);
        @(negedge clock) reset = 0;

        @(negedge clock) state_i = 3'd0;
        @(posedge clock) #2;
        chk("secret_j1", 64'(digits_o[47:0]), 64'({6'h0D, 6'h0C, 6'h07, 6'h0E, 6'h05, 6'h20, 6'h01, 6'h0B}));
        @(negedge clock) state_i = 3'd3;
        @(posedge clock) #2;
        chk("guess_j2", 64'(digits_o[47:0]), 64'({6'h05, 6'h05, 6'h0E, 6'h0C, 6'h06, 6'h20, 6'h02, 6'h0B}));

        @(negedge clock) begin state_i = 3'd4; bulls_i = 5'd2; cows_i = 5'd1; end
        pulses = 0; idx = -1; d1_first = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock) #2;
            if (result_done_o) begin pulses++; idx = i; end
            if (i == 0) begin
                chk("result_d1", 64'(digits_o[5:0]), 64'h04);
                chk("result_d5", 64'(digits_o[29:24]), 64'h02);
                d1_first = digits_o[5:0];
            end
            if (i == 1) bulls_i = 5'd9;
        end
        chk("hold_pulse_count", 64'(pulses), 64'd1);
        chk("hold_pulse_time", 64'(idx), 64'd4);
        chk("frozen_bulls", 64'(digits_o[5:0]), 64'(d1_first));

        @(negedge clock) begin state_i = 3'd2; bulls_i = 5'd20; end
        @(negedge clock) state_i = 3'd4;
        @(posedge clock) #2;
        chk("sat_bulls", 64'(digits_o[5:0]), 64'h1E);
        chk("pos8_9_blank", 64'(digits_o[59:48]), 64'({2{6'h20}}));
        pulses = 0;
        @(posedge clock) #2;
        if (result_done_o) pulses++;
        @(negedge clock) state_i = 3'd2;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock) #2;
            if (result_done_o) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);

        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clock) #2;
            found = scan_sel_o == SW'(9);
        end
        chk("scan_reach9", 64'(found), 64'd1);
        chk("scan_code_pos9", 64'(scan_code_o), 64'h20);
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(posedge clock) #2;
            found = scan_sel_o != SW'(9);
        end
        chk("scan_wrap", 64'(scan_sel_o), 64'd0);
        @(posedge clock) #2;
        chk("scan_hold", 64'(scan_sel_o), 64'd0);
        @(posedge clock) #2;
        chk("scan_step", 64'(scan_sel_o), 64'd1);

        @(negedge clock) state_i = 3'd6;
        for (int i = 0; i < 9; i++) begin
            @(posedge clock) #2;
`ifdef DISP_BLINK_EN
            vis = (i / 3) % 2 == 0;
`else
            vis = 1;
`endif
            chk("win_text", 64'(digits_o[47:0]), vis ? 64'({6'h0E, 6'h04, 6'h0E, 6'h05, 6'h09, 6'h09, 6'h0C, 6'h08}) : 64'({8{6'h20}}));
        end

        @(negedge clock) begin state_i = 3'd5; bulls_i = 5'd3; end
        repeat (2) @(posedge clock);
        @(negedge clock) #2 reset = 1;
        #1;
        chk("async_reset_digits", 64'(digits_o), 64'({ND{6'h20}}));
        chk("async_reset_sel", 64'(scan_sel_o), 64'd0);
        chk("async_reset_done", 64'(result_done_o), 64'd0);
        chk("async_reset_code", 64'(scan_code_o), 64'h20);
        @(negedge clock) reset = 0;

        for (int seg = 0; seg < 120; seg++) begin
            len = $urandom_range(1, 8);
            @(negedge clock) begin
                state_i = 3'($urandom_range(0, 7));
                bulls_i = CW'($urandom_range(0, 31));
                cows_i  = CW'($urandom_range(0, 31));
            end
            for (int j = 1; j < len; j++) begin
                @(negedge clock) if ($urandom_range(0, 1) == 1) bulls_i = CW'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 30) == 0) begin
                #2 reset = 1;
                @(negedge clock) reset = 0;
            end
        end
        repeat (3) @(posedge clock);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
